// File: rtl/sentinel_key_conditioner.sv
// Key input conditioner: synchronises and debounces the raw DIP-switch key, then
// presents accepted keys with a one-cycle strobe. Repeated wrong keys trigger a lockout.
module sentinel_key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned MAX_FAILS       = 3,
  parameter int unsigned PENALTY_CYCLES  = 1024,
  parameter logic [7:0]  KEY             = 8'hB6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] key_raw,
  output logic [7:0] key_out,
  output logic       key_valid,
  output logic       penalty_active,
  output logic [3:0] fail_cnt
);

  typedef enum logic {TRACK, PENALTY} state_t;

  localparam logic [15:0] DB_LAST    = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] PEN_LAST   = 16'(PENALTY_CYCLES - 1);
  localparam logic [4:0]  FAIL_LIMIT = 5'(MAX_FAILS);

  logic [7:0]  sync_q1, sync_q2, candidate;
  logic [15:0] db_cnt, pen_cnt;
  logic [4:0]  fail_next;
  state_t      state;

  assign fail_next = {1'b0, fail_cnt} + 5'd1;

  // The synchroniser runs regardless of ena so it never holds stale metastable data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 8'h00;
      sync_q2 <= 8'h00;
    end else begin
      sync_q1 <= key_raw;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      candidate      <= 8'h00;
      db_cnt         <= 16'd0;
      key_out        <= 8'h00;
      key_valid      <= 1'b0;
      penalty_active <= 1'b0;
      fail_cnt       <= 4'd0;
      pen_cnt        <= 16'd0;
      state          <= TRACK;
    end else begin
      key_valid <= 1'b0;
      if (ena) begin
        case (state)
          TRACK: begin
            if (sync_q2 != candidate) begin
              candidate <= sync_q2;
              db_cnt    <= 16'd0;
            end else if (db_cnt < DB_LAST) begin
              db_cnt <= db_cnt + 16'd1;
            end else if (candidate != key_out) begin
              if (candidate == KEY) begin
                key_out   <= candidate;
                key_valid <= 1'b1;
                fail_cnt  <= 4'd0;
              end else if (fail_next < FAIL_LIMIT) begin
                key_out   <= candidate;
                key_valid <= 1'b1;
                fail_cnt  <= fail_next[3:0];
              end else begin
                // Final strike: blank the key and lock out instead of presenting it.
                key_out        <= 8'h00;
                fail_cnt       <= FAIL_LIMIT[3:0];
                penalty_active <= 1'b1;
                pen_cnt        <= PEN_LAST;
                state          <= PENALTY;
              end
            end
          end
          PENALTY: begin
            if (pen_cnt == 16'd0) begin
              penalty_active <= 1'b0;
              fail_cnt       <= 4'd0;
              candidate      <= 8'h00;
              db_cnt         <= 16'd0;
              state          <= TRACK;
            end else begin
              pen_cnt <= pen_cnt - 16'd1;
            end
          end
          default: state <= TRACK;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sentinel_key_conditioner.sv
// Directed bench for sentinel_key_conditioner at default parameters.
module tb_sentinel_key_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] key_raw;
  logic [7:0] key_out;
  logic       key_valid;
  logic       penalty_active;
  logic [3:0] fail_cnt;

  int checks = 0;
  int errors = 0;

  sentinel_key_conditioner dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .key_raw(key_raw),
    .key_out(key_out), .key_valid(key_valid),
    .penalty_active(penalty_active), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply a key at edge 0 and check the acceptance edge (19) and the edge before it.
  task automatic hold_key(input logic [7:0] k, input logic exp_kv, input logic [7:0] exp_out,
                          input logic [3:0] exp_fail, input logic exp_pa, input int post);
    key_raw = k;
    tick(18);
    chk("pre_accept_kv", key_valid, 0);
    tick(1);
    chk("accept_kv", key_valid, exp_kv);
    chk("accept_out", key_out, exp_out);
    chk("accept_fail", fail_cnt, exp_fail);
    chk("accept_pa", penalty_active, exp_pa);
    if (post > 0) tick(post);
  endtask

  initial begin
    int pulses, pa_cnt, guard;
    rst_n = 1'b0; ena = 1'b1; key_raw = 8'h00;
    tick(2);
    chk("rst_key_out", key_out, 8'h00);
    chk("rst_kv", key_valid, 0);
    chk("rst_pa", penalty_active, 0);
    chk("rst_fail", fail_cnt, 0);
    rst_n = 1'b1;

    // Idle on 00: never accepted because it equals key_out.
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (key_valid) pulses++;
    end
    chk("idle_pulses", pulses, 0);
    chk("idle_key_out", key_out, 8'h00);
    chk("idle_fail", fail_cnt, 0);
    chk("idle_pa", penalty_active, 0);

    // Correct key: accepted at edge 19, no repeat pulse while held.
    hold_key(8'hB6, 1'b1, 8'hB6, 4'd0, 1'b0, 0);
    tick(1);
    chk("kv_one_cycle", key_valid, 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (key_valid) pulses++;
    end
    chk("hold_no_repulse", pulses, 0);

    // Glitch: reset to clear key_out, then B6 with a one-cycle B7 at edge 10.
    rst_n = 1'b0; key_raw = 8'h00;
    tick(1);
    rst_n = 1'b1;
    tick(5);
    key_raw = 8'hB6;
    tick(9);
    key_raw = 8'hB7;
    tick(1);
    key_raw = 8'hB6;
    tick(9);
    chk("glitch_e19_kv", key_valid, 0);
    chk("glitch_e19_out", key_out, 8'h00);
    tick(9);
    chk("glitch_e28_kv", key_valid, 0);
    tick(1);
    chk("glitch_e29_kv", key_valid, 1);
    chk("glitch_e29_out", key_out, 8'hB6);
    tick(10);

    // Wrong keys leading into penalty.
    hold_key(8'h11, 1'b1, 8'h11, 4'd1, 1'b0, 11);
    hold_key(8'h22, 1'b1, 8'h22, 4'd2, 1'b0, 11);
    hold_key(8'h33, 1'b0, 8'h00, 4'd3, 1'b1, 0);
    pa_cnt = 1; pulses = 0; guard = 0;
    while (penalty_active && guard < 2000) begin
      tick(1);
      guard++;
      if (guard == 200) key_raw = 8'hB6;
      if (key_valid) pulses++;
      if (penalty_active) begin
        pa_cnt++;
        if (key_out != 8'h00) pulses++;
      end
    end
    chk("penalty_timeout", (guard < 2000), 1);
    chk("penalty_len", pa_cnt, 1024);
    chk("penalty_ignored", pulses, 0);
    chk("exit_fail", fail_cnt, 0);
    chk("exit_key_out", key_out, 8'h00);
    tick(16);
    chk("post_pen_e16_kv", key_valid, 0);
    tick(1);
    chk("post_pen_kv", key_valid, 1);
    chk("post_pen_out", key_out, 8'hB6);
    chk("post_pen_fail", fail_cnt, 0);
    tick(5);

    // ena dropped for 50 cycles at debounce count 8.
    rst_n = 1'b0; key_raw = 8'h00;
    tick(1);
    rst_n = 1'b1;
    tick(5);
    key_raw = 8'hB6;
    tick(11);
    ena = 1'b0;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (key_valid) pulses++;
    end
    chk("ena_off_pulses", pulses, 0);
    chk("ena_off_out", key_out, 8'h00);
    ena = 1'b1;
    tick(7);
    chk("ena_e7_kv", key_valid, 0);
    tick(1);
    chk("ena_e8_kv", key_valid, 1);
    chk("ena_e8_out", key_out, 8'hB6);
    tick(5);

    // Reset mid-penalty.
    hold_key(8'h11, 1'b1, 8'h11, 4'd1, 1'b0, 11);
    hold_key(8'h22, 1'b1, 8'h22, 4'd2, 1'b0, 11);
    hold_key(8'h33, 1'b0, 8'h00, 4'd3, 1'b1, 0);
    tick(499);
    chk("mid_pen_pa", penalty_active, 1);
    #1;
    rst_n = 1'b0; key_raw = 8'hB6;
    #1;
    chk("async_rst_pa", penalty_active, 0);
    chk("async_rst_fail", fail_cnt, 0);
    chk("async_rst_out", key_out, 8'h00);
    tick(2);
    rst_n = 1'b1;
    tick(18);
    chk("rst_reaccept_e18_kv", key_valid, 0);
    tick(1);
    chk("rst_reaccept_kv", key_valid, 1);
    chk("rst_reaccept_out", key_out, 8'hB6);
    chk("rst_reaccept_pa", penalty_active, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
